// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the scripted master.
//   - HTRANS / HBURST / HRESP encodings
//   - master FSM state type
//   - hsize_f(): HSIZE encoding for a given data bus width
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR2 = 3'd3,
    ST_HALT = 3'd4
  } master_state_e;

  // HSIZE is log2 of the transfer size in bytes: 32-bit -> 3'b010, 64-bit -> 3'b011.
  function automatic logic [2:0] hsize_f(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with full/empty flags.
//   clk, rst_n   : clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata  : write request and data (ignored when full)
//   pop          : read request (ignored when empty)
//   rdata        : head entry, valid whenever empty is low (show-ahead)
//   full, empty  : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ahb_seq_master.sv
// AHB-Lite scripted master: turns queued write / read / read-compare
// commands into single AHB-Lite transfers, one at a time, with no address
// pipelining.
//
// Ports
//   HCLK, HRESETn        : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  : command handshake
//   cmd_write, cmd_addr,
//   cmd_wdata, cmd_exp,
//   cmd_mask             : command payload (mask bits of 0 are not compared)
//   HADDR, HTRANS, HWRITE,
//   HSIZE, HBURST, HWDATA: AHB-Lite master outputs (IDLE/NONSEQ, SINGLE only)
//   HRDATA, HREADY, HRESP: AHB-Lite slave responses
//   rd_data, rd_valid    : last read data and its one-cycle update strobe
//   busy                 : commands queued or a transfer in flight
//   err_count            : saturating count of compare mismatches + ERROR responses
//   timeout              : sticky bus-hang flag, master halts until reset
//   dbg_state            : current FSM state (ahb_pkg::master_state_e encoding)
//
// Handshake: a command is accepted on every rising HCLK edge where cmd_valid
// and cmd_ready are both high. cmd_ready depends only on internal state
// (FIFO not full and master not halted), never on cmd_valid; the payload
// must stay stable while cmd_valid is high and the command is not yet taken.
module ahb_seq_master
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024,
  parameter int ERR_W       = 8
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [DATA_W-1:0] cmd_exp,
  input  logic [DATA_W-1:0] cmd_mask,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic [ERR_W-1:0]  err_count,
  output logic              timeout,
  output logic [2:0]        dbg_state
);

  localparam int CMD_W  = 1 + ADDR_W + 3 * DATA_W;
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  // ---------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CMD_W-1:0] fifo_wdata;
  logic [CMD_W-1:0] fifo_rdata;

  logic              f_write;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_wdata;
  logic [DATA_W-1:0] f_exp;
  logic [DATA_W-1:0] f_mask;

  master_state_e state;

  assign fifo_wdata = {cmd_write, cmd_addr, cmd_wdata, cmd_exp, cmd_mask};
  assign {f_write, f_addr, f_wdata, f_exp, f_mask} = fifo_rdata;

  assign cmd_ready = !fifo_full && (state != ST_HALT);
  assign fifo_push = cmd_valid && cmd_ready;
  // The head is consumed on the same edge the FSM leaves IDLE.
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------
  logic              c_write;
  logic [DATA_W-1:0] c_wdata;
  logic [DATA_W-1:0] c_exp;
  logic [DATA_W-1:0] c_mask;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wd_expire;
  logic              rd_mismatch;
  logic [ERR_W-1:0]  err_inc;

  // The wait counter starts at zero on ADDR entry and counts every stalled
  // cycle of the transfer, so a hang is declared on the TIMEOUT_CYC-th
  // stalled cycle regardless of which phase stalls.
  assign wd_expire   = (wait_cnt == WAIT_LAST) && !HREADY;
  assign rd_mismatch = |((HRDATA ^ c_exp) & c_mask);
  // Saturating increment: once all-ones, further events are dropped.
  assign err_inc     = (&err_count) ? err_count : err_count + 1'b1;

  assign HSIZE     = hsize_f(DATA_W);
  assign HBURST    = HBURST_SINGLE;
  assign busy      = (state != ST_IDLE) || !fifo_empty;
  assign dbg_state = state;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      HADDR     <= '0;
      HTRANS    <= HTRANS_IDLE;
      HWRITE    <= 1'b0;
      HWDATA    <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      err_count <= '0;
      timeout   <= 1'b0;
      wait_cnt  <= '0;
      c_write   <= 1'b0;
      c_wdata   <= '0;
      c_exp     <= '0;
      c_mask    <= '0;
    end else begin
      rd_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            c_write  <= f_write;
            c_wdata  <= f_wdata;
            c_exp    <= f_exp;
            c_mask   <= f_mask;
            HADDR    <= f_addr;
            HWRITE   <= f_write;
            HTRANS   <= HTRANS_NONSEQ;
            wait_cnt <= '0;
            state    <= ST_ADDR;
          end
        end

        ST_ADDR: begin
          if (HREADY) begin
            // Address phase accepted: data phase follows with no new transfer.
            HTRANS <= HTRANS_IDLE;
            if (c_write) begin
              HWDATA <= c_wdata;
            end
            state <= ST_DATA;
          end else if (wd_expire) begin
            HTRANS  <= HTRANS_IDLE;
            timeout <= 1'b1;
            state   <= ST_HALT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (HREADY) begin
            if (HRESP == HRESP_ERROR) begin
              // Single-cycle ERROR is a slave protocol violation; still
              // count it rather than treat the data as valid.
              err_count <= err_inc;
            end else if (!c_write) begin
              rd_data  <= HRDATA;
              rd_valid <= 1'b1;
              if (rd_mismatch) begin
                err_count <= err_inc;
              end
            end
            state <= ST_IDLE;
          end else if (wd_expire) begin
            timeout <= 1'b1;
            state   <= ST_HALT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (HRESP == HRESP_ERROR) begin
              state <= ST_ERR2;
            end
          end
        end

        ST_ERR2: begin
          if (HREADY) begin
            err_count <= err_inc;
            state     <= ST_IDLE;
          end else if (wd_expire) begin
            timeout <= 1'b1;
            state   <= ST_HALT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_HALT: begin
          // Terminal until reset; bus stays idle.
          HTRANS <= HTRANS_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_seq_master.sv
module tb_ahb_seq_master;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int FIFO_DEPTH  = 4;
  localparam int TIMEOUT_CYC = 16;
  localparam int ERR_W       = 2;
  localparam int ERR_MAX     = (1 << ERR_W) - 1;

  // ---------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------
  logic              HCLK;
  logic              HRESETn;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [DATA_W-1:0] cmd_exp;
  logic [DATA_W-1:0] cmd_mask;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [DATA_W-1:0] HWDATA;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADY;
  logic              HRESP;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic [ERR_W-1:0]  err_count;
  logic              timeout;
  logic [2:0]        dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: expected error count and last read word, plus the
  // queue of read data the DUT still owes us.
  int                m_err;
  logic [DATA_W-1:0] m_rd;
  logic [DATA_W-1:0] exp_q[$];

  ahb_seq_master #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .ERR_W       (ERR_W)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_exp   (cmd_exp),
    .cmd_mask  (cmd_mask),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .err_count (err_count),
    .timeout   (timeout),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  // ---------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_err_event();
    if (m_err < ERR_MAX) m_err++;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_htrans"},    HTRANS, 2'b00);
    check({tag, "_haddr"},     HADDR, 0);
    check({tag, "_hwrite"},    HWRITE, 0);
    check({tag, "_hwdata"},    HWDATA, 0);
    check({tag, "_rd_data"},   rd_data, 0);
    check({tag, "_rd_valid"},  rd_valid, 0);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_timeout"},   timeout, 0);
  endtask

  // ---------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------
  task automatic do_reset();
    HRESETn   = 1'b0;
    cmd_valid = 1'b0;
    HREADY    = 1'b1;
    HRESP     = 1'b0;
    @(negedge HCLK);
    check_reset_values("rst");
    @(negedge HCLK);
    HRESETn = 1'b1;
    m_err   = 0;
    m_rd    = '0;
    exp_q.delete();
    @(negedge HCLK);
  endtask

  // One command end to end. aw/dw: address/data-phase wait states.
  // er: two-cycle ERROR response after dw plain wait states.
  task automatic run_cmd(input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp,
                         input logic [DATA_W-1:0] mask, input logic [DATA_W-1:0] rdata,
                         input int aw, input int dw, input logic er);
    check("cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_exp   = exp;
    cmd_mask  = mask;
    HREADY    = 1'b1;
    HRESP     = 1'b0;
    @(negedge HCLK);
    cmd_valid = 1'b0;
    check("rd_valid_pulse", rd_valid, 0);
    check("htrans_queued", HTRANS, 2'b00);
    check("busy_queued", busy, 1);
    @(negedge HCLK);
    check("htrans_nonseq", HTRANS, 2'b10);
    check("haddr", HADDR, addr);
    check("hwrite", HWRITE, wr);
    for (int i = 0; i < aw; i++) begin
      HREADY = 1'b0;
      @(negedge HCLK);
      check("htrans_addr_hold", HTRANS, 2'b10);
    end
    HREADY = 1'b1;
    @(negedge HCLK);
    check("htrans_dphase", HTRANS, 2'b00);
    if (wr) check("hwdata", HWDATA, wdata);
    for (int i = 0; i < dw; i++) begin
      HREADY = 1'b0;
      HRESP  = 1'b0;
      HRDATA = $urandom;
      @(negedge HCLK);
    end
    if (er) begin
      HREADY = 1'b0;
      HRESP  = 1'b1;
      @(negedge HCLK);
      check("err1_no_rd_valid", rd_valid, 0);
      HREADY = 1'b1;
      HRESP  = 1'b1;
      HRDATA = $urandom;
      @(negedge HCLK);
      model_err_event();
    end else begin
      HREADY = 1'b1;
      HRDATA = rdata;
      @(negedge HCLK);
      if (!wr) begin
        m_rd = rdata;
        exp_q.push_back(rdata);
        if (((rdata ^ exp) & mask) != '0) model_err_event();
      end
    end
    check("rd_valid", rd_valid, (!wr && !er));
    if (rd_valid) begin
      if (exp_q.size() == 0) check("rd_unexpected", 1, 0);
      else check("rd_data_q", rd_data, exp_q.pop_front());
    end
    check("rd_data_hold", rd_data, m_rd);
    check("err_count", err_count, m_err);
    check("busy_done", busy, 0);
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = $urandom;
  endtask

  task automatic back_to_back();
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h0000_0040;
    cmd_wdata = 32'h1111_2222;
    HREADY    = 1'b1;
    @(negedge HCLK);
    cmd_addr  = 32'h0000_0044;
    cmd_wdata = 32'h3333_4444;
    @(negedge HCLK);
    cmd_valid = 1'b0;
    check("b2b_nonseq_a", HTRANS, 2'b10);
    check("b2b_haddr_a", HADDR, 32'h40);
    @(negedge HCLK);
    check("b2b_dphase_a", HTRANS, 2'b00);
    check("b2b_hwdata_a", HWDATA, 32'h1111_2222);
    @(negedge HCLK);
    check("b2b_gap", HTRANS, 2'b00);
    check("b2b_gap_busy", busy, 1);
    @(negedge HCLK);
    check("b2b_nonseq_b", HTRANS, 2'b10);
    check("b2b_haddr_b", HADDR, 32'h44);
    @(negedge HCLK);
    check("b2b_hwdata_b", HWDATA, 32'h3333_4444);
    @(negedge HCLK);
    check("b2b_busy_done", busy, 0);
  endtask

  // Stall the first transfer in its address phase, fill the FIFO behind it,
  // then let the watchdog fire.
  task automatic hang_test();
    int n;
    int accepted;
    HREADY    = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_0100;
    @(negedge HCLK);
    cmd_valid = 1'b0;
    @(negedge HCLK);
    check("hang_nonseq", HTRANS, 2'b10);
    n = 0;
    accepted = 0;
    for (int k = 0; k < 5; k++) begin
      cmd_valid = 1'b1;
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = $urandom & 32'hFFFF_FFFC;
      cmd_wdata = $urandom;
      if (cmd_ready) accepted++;
      @(negedge HCLK);
      n++;
    end
    cmd_valid = 1'b0;
    check("fifo_accepted", accepted, FIFO_DEPTH);
    check("fifo_full_ready", cmd_ready, 0);
    check("hang_hold_nonseq", HTRANS, 2'b10);
    while (n < TIMEOUT_CYC) begin
      if (n == TIMEOUT_CYC - 1) check("timeout_early", timeout, 0);
      @(negedge HCLK);
      n++;
    end
    check("timeout_set", timeout, 1);
    check("halt_htrans", HTRANS, 2'b00);
    check("halt_ready", cmd_ready, 0);
    check("halt_busy", busy, 1);
    HREADY = 1'b1;
    repeat (4) @(negedge HCLK);
    check("halt_sticky", timeout, 1);
    check("halt_stays_idle", HTRANS, 2'b00);
    check("halt_ready_stays", cmd_ready, 0);
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    HRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_exp   = '0;
    cmd_mask  = '0;
    HRDATA    = '0;
    HREADY    = 1'b1;
    HRESP     = 1'b0;
    #1;
    check_reset_values("por");
    check("hsize", HSIZE, 3'b010);
    check("hburst", HBURST, 3'b000);
    do_reset();

    // Directed transfers
    run_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, '0, '0, '0, 0, 0, 1'b0);
    run_cmd(1'b0, 32'h0000_0010, '0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 0, 3, 1'b0);
    run_cmd(1'b0, 32'h0000_0014, '0, 32'h0, 32'h0000_00FF, 32'h1234_5601, 0, 0, 1'b0);
    run_cmd(1'b0, 32'h0000_0014, '0, 32'h0, 32'h0, 32'h1234_5601, 0, 0, 1'b0);
    run_cmd(1'b0, 32'h0000_0018, '0, 32'h0, 32'h0, 32'h0, 0, 0, 1'b1);
    run_cmd(1'b1, 32'h0000_001C, 32'hCAFE_F00D, '0, '0, '0, 1, 2, 1'b0);
    back_to_back();

    // Randomized transfers, with a reset between batches so the narrow
    // error counter is exercised both below and at saturation.
    for (int b = 0; b < 3; b++) begin
      do_reset();
      for (int i = 0; i < 6; i++) begin
        logic [DATA_W-1:0] ex;
        logic [DATA_W-1:0] mk;
        logic [DATA_W-1:0] rdv;
        ex = $urandom;
        case ($urandom_range(0, 3))
          0:       mk = '0;
          1:       mk = 32'h0000_00FF;
          2:       mk = 32'hFFFF_FFFF;
          default: mk = $urandom;
        endcase
        rdv = ($urandom_range(0, 1) == 1) ? ex : DATA_W'($urandom);
        run_cmd(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom, ex, mk, rdv,
                $urandom_range(0, 2), $urandom_range(0, 4), ($urandom_range(0, 5) == 0));
      end
    end

    // Saturation then reset in the middle of a data phase
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_cmd(1'b0, 32'h0000_0020, '0, 32'h0, 32'h0000_00FF, 32'h1234_5601, 0, 0, 1'b0);
    end
    check("err_saturated", err_count, ERR_MAX);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_0024;
    HREADY    = 1'b1;
    @(negedge HCLK);
    cmd_valid = 1'b0;
    @(negedge HCLK);
    @(negedge HCLK);
    HREADY = 1'b0;
    @(negedge HCLK);
    check("mid_data_busy", busy, 1);
    check("mid_data_err", err_count, m_err);
    HRESETn = 1'b0;
    #1;
    check_reset_values("mid_rst");
    @(negedge HCLK);
    HRESETn = 1'b1;
    HREADY  = 1'b1;
    m_err   = 0;
    m_rd    = '0;
    exp_q.delete();
    @(negedge HCLK);
    check("post_rst_busy", busy, 0);
    run_cmd(1'b1, 32'h0000_0028, 32'h5A5A_A5A5, '0, '0, '0, 0, 0, 1'b0);

    // Watchdog and full FIFO
    do_reset();
    hang_test();
    do_reset();

    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
